// File: rtl/cpuDefine.sv
// Shared definitions for the TLB maintenance sequencer: op encodings,
// sequencer states and the INVTLB op limit.
package cpuDefine;

    typedef enum logic [2:0] {
        OP_SRCH = 3'd0,
        OP_RD   = 3'd1,
        OP_WR   = 3'd2,
        OP_FILL = 3'd3,
        OP_INV  = 3'd4
    } TlbOp;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SRCH,
        ST_SRCH_CAP,
        ST_RD,
        ST_WR,
        ST_INV,
        ST_DONE
    } seq_state_e;

    localparam logic [4:0] INV_OP_MAX = 5'd6;

    function automatic logic inv_op_legal(input logic [4:0] op);
        return op <= INV_OP_MAX;
    endfunction

endpackage

// File: rtl/tlb_inv_match.sv
// Combinational INVTLB entry selector: decides whether one TLB entry is
// covered by the given invalidate op (the E bit is qualified by the caller).
module tlb_inv_match (
    input  logic        e_g,
    input  logic [9:0]  e_asid,
    input  logic [18:0] e_vppn,
    input  logic [4:0]  inv_op,
    input  logic [9:0]  inv_asid,
    input  logic [18:0] inv_va,
    output logic        match
);
    logic asid_eq;
    logic va_eq;

    always_comb begin
        asid_eq = (e_asid == inv_asid);
        va_eq   = (e_vppn == inv_va);
        match   = 1'b0;
        case (inv_op)
            5'd0, 5'd1: match = 1'b1;
            5'd2:       match = e_g;
            5'd3:       match = ~e_g;
            5'd4:       match = ~e_g && asid_eq;
            5'd5:       match = ~e_g && asid_eq && va_eq;
            5'd6:       match = (e_g || asid_eq) && va_eq;
            default:    match = 1'b0;
        endcase
    end

endmodule

// File: rtl/tlb_op_seq.sv
// Multi-cycle sequencer for TLBSRCH/TLBRD/TLBWR/TLBFILL/INVTLB.
// Define TLB_FILL_LFSR_EN to pick fill slots from a free-running LFSR.
module tlb_op_seq #(
    parameter int TLBNUM     = 16,
    parameter int TLBNUMSIZE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_type,
    input  logic [4:0]            inv_op,
    input  logic [9:0]            inv_asid,
    input  logic [18:0]           inv_va,
    input  logic [TLBNUMSIZE-1:0] csr_index,
    input  logic [9:0]            csr_asid,
    input  logic [18:0]           csr_vppn,
    output logic                  s_req,
    output logic [18:0]           s_vppn,
    output logic [9:0]            s_asid,
    input  logic                  s_hit,
    input  logic [TLBNUMSIZE-1:0] s_index,
    output logic                  s1e,
    output logic [TLBNUMSIZE-1:0] s1_index,
    output logic                  s1_ne,
    output logic [TLBNUMSIZE-1:0] r_index,
    output logic                  re,
    input  logic                  e_e,
    input  logic                  e_g,
    input  logic [9:0]            e_asid,
    input  logic [18:0]           e_vppn,
    output logic                  we,
    output logic [TLBNUMSIZE-1:0] w_index,
    output logic                  inv_we,
    output logic                  done,
    output logic                  refetch,
    output logic                  ine
);
    import cpuDefine::*;

    localparam logic [TLBNUMSIZE-1:0] LAST_IDX = TLBNUMSIZE'(TLBNUM - 1);

    seq_state_e            state;
    seq_state_e            state_n;
    TlbOp                  op_q;
    logic [TLBNUMSIZE-1:0] index_q;
    logic [9:0]            asid_q;
    logic [18:0]           vppn_q;
    logic [4:0]            inv_op_q;
    logic [9:0]            inv_asid_q;
    logic [18:0]           inv_va_q;
    logic [TLBNUMSIZE-1:0] scan_q;
    logic [TLBNUMSIZE-1:0] fill_ptr;
    logic                  accept;
    logic                  inv_hit;

    tlb_inv_match u_match (
        .e_g      (e_g),
        .e_asid   (e_asid),
        .e_vppn   (e_vppn),
        .inv_op   (inv_op_q),
        .inv_asid (inv_asid_q),
        .inv_va   (inv_va_q),
        .match    (inv_hit)
    );

    // Operands are captured at acceptance so the WB stage may move on.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_q       <= OP_SRCH;
            index_q    <= '0;
            asid_q     <= '0;
            vppn_q     <= '0;
            inv_op_q   <= '0;
            inv_asid_q <= '0;
            inv_va_q   <= '0;
            scan_q     <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                op_q       <= TlbOp'(op_type);
                index_q    <= csr_index;
                asid_q     <= csr_asid;
                vppn_q     <= csr_vppn;
                inv_op_q   <= inv_op;
                inv_asid_q <= inv_asid;
                inv_va_q   <= inv_va;
                scan_q     <= '0;
            end else if (state == ST_INV) begin
                scan_q <= scan_q + 1'b1;
            end
        end
    end

`ifdef TLB_FILL_LFSR_EN
    logic [7:0] lfsr_q;

    // Galois form of x^8+x^6+x^5+x^4+1, shifting right.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= 8'h01;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);
        end
    end

    assign fill_ptr = lfsr_q[TLBNUMSIZE-1:0];
`else
    logic [TLBNUMSIZE-1:0] fill_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q <= '0;
        end else if (state == ST_WR && op_q == OP_FILL) begin
            fill_q <= fill_q + 1'b1;
        end
    end

    assign fill_ptr = fill_q;
`endif

    assign op_ready = (state == ST_IDLE);
    assign s_vppn   = vppn_q;
    assign s_asid   = asid_q;

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        s_req    = 1'b0;
        s1e      = 1'b0;
        re       = 1'b0;
        we       = 1'b0;
        inv_we   = 1'b0;
        done     = 1'b0;
        refetch  = 1'b0;
        ine      = 1'b0;
        s1_index = s_hit ? s_index : index_q;
        s1_ne    = ~s_hit;
        r_index  = index_q;
        w_index  = index_q;
        case (state)
            ST_IDLE: begin
                if (op_valid) begin
                    case (op_type)
                        OP_SRCH: begin
                            accept  = 1'b1;
                            state_n = ST_SRCH;
                        end
                        OP_RD: begin
                            accept  = 1'b1;
                            state_n = ST_RD;
                        end
                        OP_WR, OP_FILL: begin
                            accept  = 1'b1;
                            state_n = ST_WR;
                        end
                        OP_INV: begin
                            if (inv_op_legal(inv_op)) begin
                                accept  = 1'b1;
                                state_n = ST_INV;
                            end else begin
                                ine = 1'b1;
                            end
                        end
                        default: state_n = ST_IDLE;
                    endcase
                end
            end
            ST_SRCH: begin
                s_req   = 1'b1;
                state_n = ST_SRCH_CAP;
            end
            ST_SRCH_CAP: begin
                s1e     = 1'b1;
                state_n = ST_DONE;
            end
            ST_RD: begin
                re      = 1'b1;
                state_n = ST_DONE;
            end
            ST_WR: begin
                we      = 1'b1;
                w_index = (op_q == OP_FILL) ? fill_ptr : index_q;
                state_n = ST_DONE;
            end
            ST_INV: begin
                r_index = scan_q;
                inv_we  = e_e && inv_hit;
                if (scan_q == LAST_IDX) begin
                    state_n = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                refetch = 1'b1;
                state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_tlb_op_seq.sv
// Scoreboard bench for tlb_op_seq: directed ops push expected strobe events,
// a negedge monitor pops and compares every strobe the DUT raises.
module tb_tlb_op_seq;
    localparam int TLBNUM     = 16;
    localparam int TLBNUMSIZE = 4;

    localparam int K_SREQ = 1;
    localparam int K_S1E  = 2;
    localparam int K_RE   = 3;
    localparam int K_WE   = 4;
    localparam int K_INV  = 5;
    localparam int K_DONE = 6;
    localparam int K_INE  = 7;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  op_valid;
    logic                  op_ready;
    logic [2:0]            op_type;
    logic [4:0]            inv_op;
    logic [9:0]            inv_asid;
    logic [18:0]           inv_va;
    logic [TLBNUMSIZE-1:0] csr_index;
    logic [9:0]            csr_asid;
    logic [18:0]           csr_vppn;
    logic                  s_req;
    logic [18:0]           s_vppn;
    logic [9:0]            s_asid;
    logic                  s_hit;
    logic [TLBNUMSIZE-1:0] s_index;
    logic                  s1e;
    logic [TLBNUMSIZE-1:0] s1_index;
    logic                  s1_ne;
    logic [TLBNUMSIZE-1:0] r_index;
    logic                  re;
    logic                  e_e;
    logic                  e_g;
    logic [9:0]            e_asid;
    logic [18:0]           e_vppn;
    logic                  we;
    logic [TLBNUMSIZE-1:0] w_index;
    logic                  inv_we;
    logic                  done;
    logic                  refetch;
    logic                  ine;

    logic        m_e    [TLBNUM];
    logic        m_g    [TLBNUM];
    logic [9:0]  m_asid [TLBNUM];
    logic [18:0] m_vppn [TLBNUM];

    typedef struct {
        int kind;
        int data;
        int cyc;
    } ev_t;

    ev_t exp_q[$];
    int  cyc = 0;
    int  compared = 0;
    int  mismatched = 0;
    int  a;

    tlb_op_seq #(.TLBNUM(TLBNUM), .TLBNUMSIZE(TLBNUMSIZE)) dut (
        .clk       (clk),
        .reset     (reset),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op_type   (op_type),
        .inv_op    (inv_op),
        .inv_asid  (inv_asid),
        .inv_va    (inv_va),
        .csr_index (csr_index),
        .csr_asid  (csr_asid),
        .csr_vppn  (csr_vppn),
        .s_req     (s_req),
        .s_vppn    (s_vppn),
        .s_asid    (s_asid),
        .s_hit     (s_hit),
        .s_index   (s_index),
        .s1e       (s1e),
        .s1_index  (s1_index),
        .s1_ne     (s1_ne),
        .r_index   (r_index),
        .re        (re),
        .e_e       (e_e),
        .e_g       (e_g),
        .e_asid    (e_asid),
        .e_vppn    (e_vppn),
        .we        (we),
        .w_index   (w_index),
        .inv_we    (inv_we),
        .done      (done),
        .refetch   (refetch),
        .ine       (ine)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // TLB model: entry lookup is combinational, invalidation lands on the edge.
    assign e_e    = m_e[r_index];
    assign e_g    = m_g[r_index];
    assign e_asid = m_asid[r_index];
    assign e_vppn = m_vppn[r_index];

    always @(posedge clk) begin
        if (inv_we === 1'b1) m_e[r_index] = 1'b0;
    end

    function automatic void observe(input int k, input int d);
        ev_t e;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_event: got kind=%0d data=%0h cycle=%0d, required none", k, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.data != d || e.cyc != cyc) begin
                mismatched++;
                $display("[TB] FAIL event: got kind=%0d data=%0h cycle=%0d, required kind=%0d data=%0h cycle=%0d",
                         k, d, cyc, e.kind, e.data, e.cyc);
            end
        end
    endfunction

    always @(negedge clk) begin
        if (s_req === 1'b1)  observe(K_SREQ, int'(s_vppn));
        if (s1e === 1'b1)    observe(K_S1E, int'({s1_ne, s1_index}));
        if (re === 1'b1)     observe(K_RE, int'(r_index));
        if (we === 1'b1)     observe(K_WE, int'(w_index));
        if (inv_we === 1'b1) observe(K_INV, int'(r_index));
        if (done === 1'b1)   observe(K_DONE, int'(refetch));
        if (ine === 1'b1)    observe(K_INE, 0);
    end

    task automatic push(input int k, input int d, input int c);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input string name, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic startCycle();
        @(posedge clk);
        #1;
    endtask

    // Presents one op for a single cycle, then withdraws op_valid.
    task automatic applyStimulus(input logic [2:0] t, input logic [4:0] iop,
                                 input logic [9:0] iasid, input logic [18:0] iva,
                                 input logic [3:0] idx, input logic [18:0] vppn,
                                 input logic hit, input logic [3:0] hidx);
        op_type   = t;
        inv_op    = iop;
        inv_asid  = iasid;
        inv_va    = iva;
        csr_index = idx;
        csr_vppn  = vppn;
        s_hit     = hit;
        s_index   = hidx;
        op_valid  = 1'b1;
        waitCycles(1);
        op_valid  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < TLBNUM; i++) begin
            m_e[i] = 1'b0; m_g[i] = 1'b0; m_asid[i] = '0; m_vppn[i] = '0;
        end
        reset = 1'b1; op_valid = 1'b0; op_type = '0; inv_op = '0; inv_asid = '0;
        inv_va = '0; csr_index = '0; csr_asid = 10'h055; csr_vppn = '0;
        s_hit = 1'b0; s_index = '0;
        waitCycles(3);
        reset = 1'b0;
        checkOutput("reset_op_ready", int'(op_ready), 1);
        checkOutput("reset_strobes", int'({s_req, s1e, re, we, inv_we, done, refetch, ine}), 0);

        // SRCH hit and miss
        startCycle(); a = cyc;
        push(K_SREQ, 'h00012, a + 1); push(K_S1E, 5, a + 2); push(K_DONE, 1, a + 3);
        applyStimulus(3'd0, 5'd0, 10'd0, 19'd0, 4'd9, 19'h00012, 1'b1, 4'd5);
        waitCycles(3);
        startCycle(); a = cyc;
        push(K_SREQ, 'h7FFFF, a + 1); push(K_S1E, 'h19, a + 2); push(K_DONE, 1, a + 3);
        applyStimulus(3'd0, 5'd0, 10'd0, 19'd0, 4'd9, 19'h7FFFF, 1'b0, 4'd3);
        waitCycles(3);

        // RD then WR back-to-back with op_valid held; inputs change after acceptance
        startCycle(); a = cyc;
        push(K_RE, 3, a + 1); push(K_DONE, 1, a + 2);
        push(K_WE, 6, a + 4); push(K_DONE, 1, a + 5);
        op_type = 3'd1; csr_index = 4'd3; op_valid = 1'b1;
        waitCycles(1);
        op_type = 3'd2; csr_index = 4'd6;
        waitCycles(3);
        op_valid = 1'b0;
        waitCycles(2);

        // FILL x17: round-robin pointer from 0, wrapping after 16
        for (int n = 0; n < 17; n++) begin
            startCycle(); a = cyc;
            push(K_WE, n % TLBNUM, a + 1); push(K_DONE, 1, a + 2);
            applyStimulus(3'd3, 5'd0, 10'd0, 19'd0, 4'd12, 19'd0, 1'b0, 4'd0);
            waitCycles(2);
        end

        // INV op 5: only entry 2 qualifies
        m_e[2] = 1'b1; m_g[2] = 1'b0; m_asid[2] = 10'd3; m_vppn[2] = 19'h0ABCD;
        m_e[7] = 1'b1; m_g[7] = 1'b1; m_asid[7] = 10'd3; m_vppn[7] = 19'h0ABCD;
        m_e[4] = 1'b1; m_g[4] = 1'b0; m_asid[4] = 10'd3; m_vppn[4] = 19'h01111;
        startCycle(); a = cyc;
        push(K_INV, 2, a + 3); push(K_DONE, 1, a + 17);
        applyStimulus(3'd4, 5'd5, 10'd3, 19'h0ABCD, 4'd0, 19'd0, 1'b0, 4'd0);
        waitCycles(17);
        checkOutput("inv5_entry2_cleared", int'(m_e[2]), 0);
        checkOutput("inv5_entry7_kept", int'(m_e[7]), 1);

        // INV op 2: global entries only
        startCycle(); a = cyc;
        push(K_INV, 7, a + 8); push(K_DONE, 1, a + 17);
        applyStimulus(3'd4, 5'd2, 10'd0, 19'd0, 4'd0, 19'd0, 1'b0, 4'd0);
        waitCycles(17);
        checkOutput("inv2_entry4_kept", int'(m_e[4]), 1);

        // INV op 7: illegal, ine only
        startCycle(); a = cyc;
        push(K_INE, 0, a);
        applyStimulus(3'd4, 5'd7, 10'd0, 19'd0, 4'd0, 19'd0, 1'b0, 4'd0);
        checkOutput("ine_op_ready", int'(op_ready), 1);
        waitCycles(4);

        // Reset during INV op 0 at scan index 8
        for (int i = 0; i < TLBNUM; i++) begin
            m_e[i] = 1'b1; m_g[i] = 1'b0;
        end
        startCycle(); a = cyc;
        for (int i = 0; i <= 8; i++) push(K_INV, i, a + 1 + i);
        applyStimulus(3'd4, 5'd0, 10'd0, 19'd0, 4'd0, 19'd0, 1'b0, 4'd0);
        waitCycles(8);
        reset = 1'b1;
        waitCycles(1);
        checkOutput("abort_op_ready", int'(op_ready), 1);
        checkOutput("abort_strobes", int'({s_req, s1e, re, we, inv_we, done, refetch, ine}), 0);
        reset = 1'b0;
        checkOutput("abort_entry8_cleared", int'(m_e[8]), 0);
        for (int i = 9; i < TLBNUM; i++) checkOutput($sformatf("abort_entry%0d_kept", i), int'(m_e[i]), 1);

        // Recovery after abort
        startCycle(); a = cyc;
        push(K_RE, 4, a + 1); push(K_DONE, 1, a + 2);
        applyStimulus(3'd1, 5'd0, 10'd0, 19'd0, 4'd4, 19'd0, 1'b0, 4'd0);
        waitCycles(6);

        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
